// File: rtl/coin_return_sequencer_if.sv
// Coin-hopper handshake bundle between the change-return requester and the
// serial coin dispenser.
interface coin_return_if #(
  parameter int TOTAL_BITS = 31,
  parameter int NUM_COINS  = 3,
  parameter int CNT_BITS   = 8
);
  logic                  i_start;
  logic [TOTAL_BITS-1:0] i_total;
  logic [NUM_COINS-1:0]  o_return_coin;
  logic                  o_busy;
  logic                  o_done;
  logic [TOTAL_BITS-1:0] o_remaining;
  logic [CNT_BITS-1:0]   o_coin_count;

  modport master (
    output i_start, i_total,
    input  o_return_coin, o_busy, o_done, o_remaining, o_coin_count
  );

  modport slave (
    input  i_start, i_total,
    output o_return_coin, o_busy, o_done, o_remaining, o_coin_count
  );
endinterface

// File: rtl/coin_return_sequencer.sv
// Serial change dispenser: ejects one coin per clock, largest denomination
// first, then pulses done and leaves the unpayable residual on o_remaining.
module coin_return_sequencer #(
  parameter int TOTAL_BITS  = 31,
  parameter int NUM_COINS   = 3,
  parameter int COIN0_VALUE = 100,
  parameter int COIN1_VALUE = 500,
  parameter int COIN2_VALUE = 1000,
  parameter int CNT_BITS    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  coin_return_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DISPENSE = 1'b1
  } state_t;

  localparam logic [TOTAL_BITS-1:0] COIN0_V = TOTAL_BITS'(COIN0_VALUE);
  localparam logic [TOTAL_BITS-1:0] COIN1_V = TOTAL_BITS'(COIN1_VALUE);
  localparam logic [TOTAL_BITS-1:0] COIN2_V = TOTAL_BITS'(COIN2_VALUE);
  localparam logic [CNT_BITS-1:0]   CNT_MAX = {CNT_BITS{1'b1}};

  state_t                state_q, state_d;
  logic [NUM_COINS-1:0]  coin_q, coin_d;
  logic                  done_q, done_d;
  logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
  logic [CNT_BITS-1:0]   count_q, count_d;

  logic                  sel_fit_s;
  logic [NUM_COINS-1:0]  sel_coin_s;
  logic [TOTAL_BITS-1:0] sel_value_s;

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      coin_q      <= '0;
      done_q      <= 1'b0;
      remaining_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
    end
  end

  // Greedy pick of the largest coin that still fits the amount owed.
  always_comb begin
    sel_fit_s   = 1'b1;
    sel_coin_s  = '0;
    sel_value_s = '0;
    if (remaining_q >= COIN2_V) begin
      sel_coin_s[2] = 1'b1;
      sel_value_s   = COIN2_V;
    end else if (remaining_q >= COIN1_V) begin
      sel_coin_s[1] = 1'b1;
      sel_value_s   = COIN1_V;
    end else if (remaining_q >= COIN0_V) begin
      sel_coin_s[0] = 1'b1;
      sel_value_s   = COIN0_V;
    end else begin
      sel_fit_s = 1'b0;
    end
  end

  // Next-state: leave IDLE on a request, return once nothing more fits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = DISPENSE;
        end else begin
          state_d = IDLE;
        end
      end
      DISPENSE: begin
        if (sel_fit_s) begin
          state_d = DISPENSE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values; the balance is captured only when a request is accepted.
  always_comb begin
    coin_d      = '0;
    done_d      = 1'b0;
    remaining_d = remaining_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          remaining_d = bus.i_total;
          count_d     = '0;
        end else begin
          remaining_d = remaining_q;
        end
      end
      DISPENSE: begin
        if (sel_fit_s) begin
          coin_d      = sel_coin_s;
          remaining_d = remaining_q - sel_value_s;
          if (count_q != CNT_MAX) begin
            count_d = count_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
          end else begin
            count_d = count_q;
          end
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        coin_d = '0;
        done_d = 1'b0;
      end
    endcase
  end

  assign bus.o_return_coin = coin_q;
  assign bus.o_done        = done_q;
  assign bus.o_remaining   = remaining_q;
  assign bus.o_coin_count  = count_q;
  assign bus.o_busy        = (state_q == DISPENSE);

endmodule

// File: tb/tb_coin_return_sequencer.sv
// Directed bench for coin_return_sequencer with a greedy change model checked every cycle.
module tb_coin_return_sequencer;

  logic clk = 1'b0;
  logic reset_n;

  coin_return_if #(.TOTAL_BITS(31), .NUM_COINS(3), .CNT_BITS(8)) bus ();

  coin_return_sequencer #(
    .TOTAL_BITS(31), .NUM_COINS(3), .COIN0_VALUE(100),
    .COIN1_VALUE(500), .COIN2_VALUE(1000), .CNT_BITS(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: a planned list of coins per accepted request.
  int unsigned   coin_val [3] = '{100, 500, 1000};
  int            plan_q [$];
  logic [30:0]   m_rem  = '0;
  logic [7:0]    m_cnt  = '0;
  logic          m_busy = 1'b0;
  logic [2:0]    m_coin = '0;
  logic          m_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Break an amount into its greedy coin list with plain division.
  task automatic plan(input int unsigned total);
    int unsigned r, n;
    plan_q.delete();
    r = total;
    n = r / 1000; r = r % 1000;
    repeat (n) plan_q.push_back(2);
    n = r / 500;  r = r % 500;
    repeat (n) plan_q.push_back(1);
    n = r / 100;
    repeat (n) plan_q.push_back(0);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_rem = '0; m_cnt = '0; m_busy = 1'b0; m_coin = '0; m_done = 1'b0;
        plan_q.delete();
      end else begin
        m_coin = '0;
        m_done = 1'b0;
        if (!m_busy) begin
          if (bus.i_start === 1'b1) begin
            plan(int'(bus.i_total));
            m_busy = 1'b1;
            m_rem  = bus.i_total;
            m_cnt  = '0;
          end
        end else if (plan_q.size() != 0) begin
          int c;
          c = plan_q.pop_front();
          m_coin = 3'b001 << c;
          m_rem  = m_rem - 31'(coin_val[c]);
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("coin",  64'(bus.o_return_coin), 64'(m_coin));
        chk("done",  64'(bus.o_done),        64'(m_done));
        chk("busy",  64'(bus.o_busy),        64'(m_busy));
        chk("rem",   64'(bus.o_remaining),   64'(m_rem));
        chk("count", 64'(bus.o_coin_count),  64'(m_cnt));
      end
    end
  end

  // Request is sampled on the next rising edge; returns at the following falling edge.
  task automatic start_req(input int unsigned total);
    bus.i_start = 1'b1;
    bus.i_total = 31'(total);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_total = 31'd7;
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) seen = 1'b1;
    end
    chk("done_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    bus.i_start = 1'b0;
    bus.i_total = '0;
    repeat (2) @(negedge clk);
    chk("rst_coin",  64'(bus.o_return_coin), 64'd0);
    chk("rst_busy",  64'(bus.o_busy),        64'd0);
    chk("rst_done",  64'(bus.o_done),        64'd0);
    chk("rst_rem",   64'(bus.o_remaining),   64'd0);
    chk("rst_count", 64'(bus.o_coin_count),  64'd0);
    chk_en  = 1'b1;
    #2 reset_n = 1'b1;
    @(negedge clk);

    start_req(1600);
    chk("t1600_busy", 64'(bus.o_busy), 64'd1);
    chk("t1600_c0",   64'(bus.o_return_coin), 64'd0);
    @(negedge clk); chk("t1600_c1", 64'(bus.o_return_coin), 64'd4);
    @(negedge clk); chk("t1600_c2", 64'(bus.o_return_coin), 64'd2);
    @(negedge clk); chk("t1600_c3", 64'(bus.o_return_coin), 64'd1);
    @(negedge clk);
    chk("t1600_done", 64'(bus.o_done), 64'd1);
    chk("t1600_coin", 64'(bus.o_return_coin), 64'd0);
    chk("t1600_rem",  64'(bus.o_remaining), 64'd0);
    chk("t1600_cnt",  64'(bus.o_coin_count), 64'd3);
    @(negedge clk);
    chk("t1600_done_pulse", 64'(bus.o_done), 64'd0);

    start_req(250);
    @(negedge clk); chk("t250_c1", 64'(bus.o_return_coin), 64'd1);
    @(negedge clk); chk("t250_c2", 64'(bus.o_return_coin), 64'd1);
    @(negedge clk);
    chk("t250_done", 64'(bus.o_done), 64'd1);
    chk("t250_rem",  64'(bus.o_remaining), 64'd50);
    chk("t250_cnt",  64'(bus.o_coin_count), 64'd2);
    // Back-to-back request issued during the done cycle.
    start_req(100);
    chk("b2b_busy", 64'(bus.o_busy), 64'd1);
    chk("b2b_cnt0", 64'(bus.o_coin_count), 64'd0);
    @(negedge clk);
    chk("b2b_coin", 64'(bus.o_return_coin), 64'd1);
    chk("b2b_cnt1", 64'(bus.o_coin_count), 64'd1);
    @(negedge clk);
    chk("b2b_done", 64'(bus.o_done), 64'd1);
    chk("b2b_rem",  64'(bus.o_remaining), 64'd0);
    @(negedge clk);

    start_req(0);
    chk("t0_busy1", 64'(bus.o_busy), 64'd1);
    chk("t0_coin",  64'(bus.o_return_coin), 64'd0);
    @(negedge clk);
    chk("t0_done",  64'(bus.o_done), 64'd1);
    chk("t0_busy0", 64'(bus.o_busy), 64'd0);
    chk("t0_rem",   64'(bus.o_remaining), 64'd0);
    @(negedge clk);

    start_req(3000);
    bus.i_start = 1'b1;
    bus.i_total = 31'd500;
    @(negedge clk);
    bus.i_start = 1'b0;
    chk("t3000_c1", 64'(bus.o_return_coin), 64'd4);
    @(negedge clk); chk("t3000_c2", 64'(bus.o_return_coin), 64'd4);
    @(negedge clk); chk("t3000_c3", 64'(bus.o_return_coin), 64'd4);
    @(negedge clk);
    chk("t3000_done", 64'(bus.o_done), 64'd1);
    chk("t3000_rem",  64'(bus.o_remaining), 64'd0);
    chk("t3000_cnt",  64'(bus.o_coin_count), 64'd3);
    @(negedge clk);
    chk("t3000_idle", 64'(bus.o_busy), 64'd0);

    start_req(1999);
    wait_done(20);
    chk("t1999_rem", 64'(bus.o_remaining), 64'd99);
    chk("t1999_cnt", 64'(bus.o_coin_count), 64'd6);
    @(negedge clk);

    start_req(300000);
    wait_done(400);
    chk("sat_cnt", 64'(bus.o_coin_count), 64'd255);
    chk("sat_rem", 64'(bus.o_remaining), 64'd0);
    @(negedge clk);

    start_req(1600);
    @(negedge clk);
    chk("rmid_c1", 64'(bus.o_return_coin), 64'd4);
    #2 reset_n = 1'b0;
    #1;
    chk("rmid_coin",  64'(bus.o_return_coin), 64'd0);
    chk("rmid_busy",  64'(bus.o_busy),        64'd0);
    chk("rmid_rem",   64'(bus.o_remaining),   64'd0);
    chk("rmid_count", 64'(bus.o_coin_count),  64'd0);
    chk("rmid_done",  64'(bus.o_done),        64'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rmid_after_coin", 64'(bus.o_return_coin), 64'd0);
    chk("rmid_after_busy", 64'(bus.o_busy), 64'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
